desc_bank_writer: RTL and testbench

Write-side controller for the matching stage's descriptor bank memory (1280-bit words, 32 entries, synchronous write, combinational read). It accepts a descriptor as a serial stream of 128 ten-bit elements over a valid/ready handshake and packs them into one 1280-bit word. It then issues a single-cycle write to the bank at an incrementing address, and tracks how many descriptors are stored so the downstream matcher knows how many entries to scan.

---
 rtl/desc_bank_writer_if.sv | 26 ++
 rtl/desc_bank_writer.sv | 75 +++++++
 tb/tb_desc_bank_writer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/desc_bank_writer_if.sv
// desc_bank_writer_if: element stream in, descriptor bank write port and status out
interface desc_bank_writer_if #(
  parameter int ELEM_WIDTH = 10,
  parameter int NUM_ELEMS  = 128,
  parameter int ADDR_WIDTH = 5
);
  logic                             clear;
  logic                             in_valid;
  logic [ELEM_WIDTH-1:0]            in_elem;
  logic                             in_last;
  logic                             in_ready;
  logic [ELEM_WIDTH*NUM_ELEMS-1:0]  mem_data;
  logic [ADDR_WIDTH-1:0]            mem_addr;
  logic                             mem_we;
  logic [ADDR_WIDTH:0]              count;
  logic                             full;
  logic                             err;
  modport master (
    output clear, in_valid, in_elem, in_last,
    input  in_ready, mem_data, mem_addr, mem_we, count, full, err
  );
  modport slave (
    input  clear, in_valid, in_elem, in_last,
    output in_ready, mem_data, mem_addr, mem_we, count, full, err
  );
endinterface

// File: rtl/desc_bank_writer.sv
// desc_bank_writer: packs a serial element stream into one wide word and writes it to the descriptor bank
module desc_bank_writer #(
  parameter int ELEM_WIDTH = 10,
  parameter int NUM_ELEMS  = 128,
  parameter int ADDR_WIDTH = 5
) (
  input logic               clk,
  input logic               rst,
  desc_bank_writer_if.slave bus
);
  localparam int EW = $clog2(NUM_ELEMS);
  localparam logic [EW-1:0] LAST_E = EW'(NUM_ELEMS - 1);
  localparam logic [ADDR_WIDTH:0] CAP_M1 = (ADDR_WIDTH+1)'((2 ** ADDR_WIDTH) - 1);
  typedef enum logic [1:0] {FILL, WRITE, FULL} state_t;
  state_t                          state_q, state_d;
  logic [EW-1:0]                   e_q;
  logic [ELEM_WIDTH*NUM_ELEMS-1:0] pack_q;
  logic [ADDR_WIDTH-1:0]           ptr_q;
  logic [ADDR_WIDTH:0]             count_q;
  logic                            err_q;
  logic                            acc, is_end, bad;
  // accept decode and framing check against the current element index
  always_comb begin
    acc    = bus.in_valid && state_q == FILL;
    is_end = e_q == LAST_E;
    bad    = acc && (bus.in_last != is_end);
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end
  // next state: clear wins, a well-framed final element enters WRITE, WRITE lasts one cycle
  always_comb begin
    state_d = bus.clear                       ? FILL :
              (acc && is_end && bus.in_last)  ? WRITE :
              state_q == WRITE                ? (count_q == CAP_M1 ? FULL : FILL) :
              state_q;
  end
  // outputs are pure decodes of registered state; clear suppresses a pending write
  always_comb begin
    bus.in_ready = state_q == FILL;
    bus.mem_we   = state_q == WRITE && !bus.clear;
    bus.full     = state_q == FULL;
    bus.mem_addr = ptr_q;
    bus.mem_data = pack_q;
    bus.count    = count_q;
    bus.err      = err_q;
  end
  // packing, element index, write pointer, descriptor count and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q     <= '0;
      pack_q  <= '0;
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (bus.clear) begin
      e_q     <= '0;
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (acc) begin
        pack_q[e_q*ELEM_WIDTH +: ELEM_WIDTH] <= bus.in_elem;
        e_q <= (bad || is_end) ? '0 : e_q + 1'b1;
      end
      if (bad) err_q <= 1'b1;
      if (state_q == WRITE) begin
        ptr_q   <= ptr_q + 1'b1;
        count_q <= count_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_desc_bank_writer.sv
// tb_desc_bank_writer: scoreboard bench for the descriptor bank writer
module tb_desc_bank_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  desc_bank_writer_if #(.ELEM_WIDTH(10), .NUM_ELEMS(128), .ADDR_WIDTH(5)) bus ();
  desc_bank_writer #(.ELEM_WIDTH(10), .NUM_ELEMS(128), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int n_cmp = 0;
  int n_err = 0;
  logic [4:0]    q_addr[$];
  logic [1279:0] q_data[$];
  logic [4:0]    exp_ptr = '0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] fold(input logic [1279:0] d);
    logic [63:0] h = '0;
    for (int i = 0; i < 20; i++) h = {h[62:0], h[63]} ^ d[i*64 +: 64];
    return h;
  endfunction
  always @(negedge clk) begin
    if (bus.mem_we) begin
      if (q_addr.size() == 0) chk("unexp_we", {63'd0, bus.mem_we}, 64'd0);
      else begin
        chk("wr_addr", {59'd0, bus.mem_addr}, {59'd0, q_addr.pop_front()});
        chk("wr_data", fold(bus.mem_data), fold(q_data.pop_front()));
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [9:0] v, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_elem  = v;
    bus.in_last  = last;
    while (!bus.in_ready && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) chk("rdy_timeout", {63'd0, bus.in_ready}, 64'd1);
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask
  task automatic send(input logic [9:0] base, input int stop_at, input bit last_ok, input bit push);
    logic [1279:0] d = '0;
    logic [9:0] v;
    for (int e = 0; e < 128; e++) begin
      v = 10'(int'(base) + e);
      d[e*10 +: 10] = v;
      put(v, (e == stop_at) || (e == 127 && last_ok));
      if (e == stop_at) break;
    end
    if (push) begin
      q_addr.push_back(exp_ptr);
      q_data.push_back(d);
      exp_ptr++;
    end
  endtask
  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    exp_ptr = '0;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"},  {63'd0, bus.in_ready}, 64'd1);
    chk({tag, "_we"},   {63'd0, bus.mem_we}, 64'd0);
    chk({tag, "_addr"}, {59'd0, bus.mem_addr}, 64'd0);
    chk({tag, "_data"}, fold(bus.mem_data), 64'd0);
    chk({tag, "_cnt"},  {58'd0, bus.count}, 64'd0);
    chk({tag, "_full"}, {63'd0, bus.full}, 64'd0);
    chk({tag, "_err"},  {63'd0, bus.err}, 64'd0);
  endtask
  initial begin
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_elem = '0;
    bus.in_last = 1'b0;
    #1;
    chk_reset_vals("rst");
    step();
    step();
    rst = 1'b0;
    chk_reset_vals("rel");
    // single descriptor, element value = index
    send(10'd0, -1, 1'b1, 1'b1);
    chk("t1_rdy_wr", {63'd0, bus.in_ready}, 64'd0);
    chk("t1_we_wr",  {63'd0, bus.mem_we}, 64'd1);
    step();
    chk("t1_cnt", {58'd0, bus.count}, 64'd1);
    chk("t1_rdy", {63'd0, bus.in_ready}, 64'd1);
    // fill the bank with 32 back-to-back descriptors
    do_clear();
    for (int k = 0; k < 32; k++) send(10'(k * 37 + 5), -1, 1'b1, 1'b1);
    step();
    chk("t2_cnt",  {58'd0, bus.count}, 64'd32);
    chk("t2_full", {63'd0, bus.full}, 64'd1);
    chk("t2_rdy",  {63'd0, bus.in_ready}, 64'd0);
    bus.in_valid = 1'b1;
    bus.in_last = 1'b1;
    for (int i = 0; i < 20; i++) step();
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    chk("t2_cnt_hold", {58'd0, bus.count}, 64'd32);
    chk("t2_full_hold", {63'd0, bus.full}, 64'd1);
    // early in_last on element 50
    do_clear();
    chk("t3_clr_full", {63'd0, bus.full}, 64'd0);
    send(10'd100, 50, 1'b0, 1'b0);
    step();
    chk("t3_err", {63'd0, bus.err}, 64'd1);
    chk("t3_cnt", {58'd0, bus.count}, 64'd0);
    send(10'd200, -1, 1'b1, 1'b1);
    step();
    chk("t3_cnt_after", {58'd0, bus.count}, 64'd1);
    chk("t3_err_sticky", {63'd0, bus.err}, 64'd1);
    // missing in_last on element 127
    do_clear();
    send(10'd300, -1, 1'b0, 1'b0);
    step();
    step();
    chk("t4_err", {63'd0, bus.err}, 64'd1);
    chk("t4_cnt", {58'd0, bus.count}, 64'd0);
    do_clear();
    chk("t4_err_clr", {63'd0, bus.err}, 64'd0);
    // clear during the WRITE cycle of the 3rd descriptor
    send(10'd400, -1, 1'b1, 1'b1);
    send(10'd500, -1, 1'b1, 1'b1);
    send(10'd600, -1, 1'b1, 1'b0);
    bus.clear = 1'b1;
    #1;
    chk("t5_we_sup", {63'd0, bus.mem_we}, 64'd0);
    step();
    bus.clear = 1'b0;
    exp_ptr = '0;
    chk("t5_cnt", {58'd0, bus.count}, 64'd0);
    send(10'd700, -1, 1'b1, 1'b1);
    step();
    chk("t5_cnt_after", {58'd0, bus.count}, 64'd1);
    // reset pulse 60 elements into the 2nd descriptor
    do_clear();
    send(10'd800, -1, 1'b1, 1'b1);
    for (int e = 0; e < 60; e++) put(10'(900 + e), 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_vals("t6");
    exp_ptr = '0;
    step();
    rst = 1'b0;
    send(10'd1000, -1, 1'b1, 1'b1);
    step();
    chk("t6_cnt", {58'd0, bus.count}, 64'd1);
    step();
    chk("sb_empty", 64'(q_addr.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
